// File: rtl/hack_ram_arbiter_if.sv
// Bus bundle for hack_ram_arbiter: CPU data port, DMA/debug port and the RAM side.
// The arbiter binds the slave modport; whatever drives the requests and models the RAM binds master.
interface hack_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_address, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_address, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/hack_ram_arbiter.sv
// Shares the single-port Hack data RAM between the CPU (default priority) and a DMA master,
// with a starvation counter forcing a DMA slot. Define ARB_PERF_CNT_EN for perf counters.
module hack_ram_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Reset,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_dma_cnt,
`endif
  hack_ram_arbiter_if.slave bus
);

  localparam logic [7:0] LimitW = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StWait, StForce} state_e;

  state_e     state_q, state_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       dma_rvalid_q, dma_rvalid_d;

  logic       force_slot;
  logic       dma_gnt;
  logic       dma_denied;
  logic [7:0] starve_cnt_inc;

  // Grants are masked while Reset is low so nothing reaches the RAM during reset.
  assign force_slot = Reset && (state_q == StForce) && bus.dma_req;
  assign dma_gnt    = Reset && bus.dma_req && (force_slot || !bus.cpu_req);
  assign dma_denied = bus.dma_req && !dma_gnt;

  assign bus.dma_gnt     = dma_gnt;
  assign bus.cpu_stall   = force_slot;
  assign bus.ram_address = dma_gnt ? bus.dma_addr : bus.cpu_addr;
  assign bus.ram_we      = Reset && (dma_gnt ? bus.dma_we : (bus.cpu_req && bus.cpu_we));
  assign bus.ram_wdata   = dma_gnt ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.cpu_rdata   = bus.ram_rdata;
  assign bus.dma_rdata   = bus.ram_rdata;
  assign bus.dma_rvalid  = dma_rvalid_q;

  assign starve_cnt_inc = starve_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dma_denied) begin
          starve_cnt_d = 8'd1;
          state_d      = (8'd1 >= LimitW) ? StForce : StWait;
        end
      end
      StWait: begin
        if (dma_denied) begin
          starve_cnt_d = starve_cnt_inc;
          if (starve_cnt_inc >= LimitW) state_d = StForce;
        end else begin
          state_d      = StIdle;
          starve_cnt_d = '0;
        end
      end
      StForce: begin
        state_d      = StIdle;
        starve_cnt_d = '0;
      end
      default: begin
        state_d      = StIdle;
        starve_cnt_d = '0;
      end
    endcase
    dma_rvalid_d = dma_gnt && !bus.dma_we;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] dma_cnt_q, dma_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    dma_cnt_d   = dma_cnt_q;
    if (force_slot && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (dma_gnt && (dma_cnt_q != 16'hFFFF))      dma_cnt_d   = dma_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stall_cnt_q <= '0;
      dma_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      dma_cnt_q   <= dma_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_dma_cnt   = dma_cnt_q;
`endif

endmodule
